trace_capture_ctrl: RTL and testbench
=====================================

TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 Parameter Fpay, default 32, trace word width in bits.
REQ-002 Parameter Tile_num, default 4, number of trace requesters.
REQ-003 Parameter TB_AW, default 9, trace buffer address width; the buffer holds 2^TB_AW words.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 arm  in  1  single-cycle pulse that starts a new capture.
REQ-008 stop  in  1  single-cycle pulse that forces the capture to end.
REQ-009 trig_in  in  1  trigger event, level-sampled.
REQ-010 post_len  in  TB_AW  number of words to capture after the trigger; latched when the trigger is taken.
REQ-011 src_mask  in  Tile_num  per-source capture enable.
REQ-012 src_req  in  Tile_num  per-source write request; held high until acknowledged.
REQ-013 src_data  in  Tile_num*Fpay  source i occupies bits [i*Fpay +: Fpay].
REQ-014 src_ack  out  Tile_num  one-hot grant, combinational in the same cycle.
REQ-015 tb_wr_en / tb_wr_addr / tb_din  out  1 / TB_AW / Fpay  buffer write port.
REQ-016 tb_rd_en / tb_rd_addr  out  1 / TB_AW  buffer read port; the buffer returns data 1 cycle after tb_rd_en.
REQ-017 rd_next  in  1  readout word request, one word per pulse.
REQ-018 rd_start  in  1  pulse that begins readout.
REQ-019 rd_valid / rd_last  out  1 / 1  readout data valid and final-word marker.
REQ-020 state  out  3  IDLE=0, ARMED=1, TRIG=2, DONE=3, READ=4.
REQ-021 wrapped  out  1  sticky flag: the write pointer has wrapped since arm.

Function
REQ-022 Arbitration SHALL be round-robin over the set (src_req & src_mask), and SHALL occur only in ARMED or TRIG.
- At most one grant per cycle.
- After granting source g, the highest priority moves to (g+1) mod Tile_num.
- With no grant, the priority pointer is unchanged.
REQ-023 Write port behaviour SHALL be as follows.
- tb_wr_en = |src_ack.
- tb_din = data of the granted source.
- tb_wr_addr = wr_ptr.
- wr_ptr increments after each write, modulo 2^TB_AW.
- wrapped sets on the increment from 2^TB_AW-1 to 0.
REQ-024 In IDLE, DONE and READ, src_ack SHALL be 0 and tb_wr_en SHALL be 0.
REQ-025 The IDLE or DONE to ARMED transition on arm SHALL:
- clear wr_ptr and wrapped;
- reset the priority pointer to source 0.
- arm is ignored in ARMED, TRIG and READ.
REQ-026 ARMED behaviour SHALL be as follows.
- Writes are circular, overwriting the oldest entries.
- trig_in=1 moves the block to TRIG on the next edge and loads post_cnt=post_len.
- A write in the same cycle as trig_in counts as pre-trigger.
REQ-027 TRIG behaviour SHALL be as follows.
- Each write decrements post_cnt.
- A write with post_cnt==1 moves the block to DONE on that edge; no further grants follow.
- post_cnt==0 on entry moves the block to DONE on the next edge with zero post-trigger writes.
REQ-028 stop in ARMED or TRIG SHALL move the block to DONE on the next edge.
- The write granted in the stop cycle still completes.
- stop has priority over trig_in in the same cycle.
REQ-029 rd_start in DONE SHALL move the block to READ.
- rd_ptr is loaded with wr_ptr if wrapped=1, else 0.
- rd_rem is loaded with 2^TB_AW if wrapped=1, else wr_ptr.
- rd_rem==0 returns the block directly to IDLE.
REQ-030 In READ, rd_next SHALL:
- assert tb_rd_en with tb_rd_addr=rd_ptr in the same cycle;
- increment rd_ptr (with wrap) and decrement rd_rem.
- rd_valid asserts exactly 1 cycle later.
- rd_last accompanies the rd_valid of the word issued with rd_rem==1.
- After that word is issued, the block moves to IDLE.
- rd_next in any other state is ignored.
REQ-031 rd_rem SHALL be TB_AW+1 bits wide; all pointers SHALL wrap silently.
REQ-032 reset SHALL have priority over all inputs in the same cycle, including mid-capture and mid-readout.

Reset
REQ-033 On reset:
- state=IDLE;
- wr_ptr, rd_ptr, rd_rem and post_cnt are 0;
- wrapped=0;
- priority pointer = source 0;
- src_ack, tb_wr_en, tb_rd_en, rd_valid and rd_last are 0.

Verification
REQ-034 All four sources request continuously in ARMED, with mask=4'b1111 -> grants cycle 0,1,2,3,0; tb_wr_addr runs 0,1,2,3,4.
REQ-035 Only source 2 is unmasked, with trig_in at write 5 and post_len=3 -> words at addresses 0..8 are written and the block enters DONE; wrapped=0; readout gives 9 words from address 0, with rd_last on the 9th.
REQ-036 TB_AW=3 and 11 pre-trigger writes, then stop -> wrapped=1; readout gives 8 words starting at address 3, with rd_last on the 8th.
REQ-037 trig_in with post_len=0 -> the block is in DONE on the next edge and no further tb_wr_en.
REQ-038 reset asserted during READ at rd_rem=4 -> the next cycle has state=IDLE and rd_valid=0; a following rd_next produces no tb_rd_en.

Source files
------------

// File: rtl/trace_capture_ctrl.sv
// Trace capture controller: round-robin capture of per-tile trace words into a
// circular buffer around a trigger, followed by oldest-first readout.
module trace_capture_ctrl #(
  parameter int Fpay     = 32,
  parameter int Tile_num = 4,
  parameter int TB_AW    = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     trig_in,
  input  logic [TB_AW-1:0]         post_len,
  input  logic [Tile_num-1:0]      src_mask,
  input  logic [Tile_num-1:0]      src_req,
  input  logic [Tile_num*Fpay-1:0] src_data,
  output logic [Tile_num-1:0]      src_ack,
  output logic                     tb_wr_en,
  output logic [TB_AW-1:0]         tb_wr_addr,
  output logic [Fpay-1:0]          tb_din,
  output logic                     tb_rd_en,
  output logic [TB_AW-1:0]         tb_rd_addr,
  input  logic                     rd_next,
  input  logic                     rd_start,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic [2:0]               state,
  output logic                     wrapped
);

  localparam int PW = (Tile_num > 1) ? $clog2(Tile_num) : 1;

  // Handshake: a source holds src_req until src_ack is high in the same cycle;
  // that cycle is the transfer. Readout issues one word per rd_next and the
  // word is valid (rd_valid) exactly one cycle later.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_TRIG  = 3'd2,
    S_DONE  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [TB_AW-1:0]    wr_ptr, rd_ptr, post_cnt;
  logic [TB_AW:0]      rd_rem, rd_len;
  logic                wrapped_q;
  logic [PW-1:0]       prio_q, gnt_idx, cand, prio_next;
  logic                grant_en, found, arm_take, rd_take, rd_issue;
  logic [Tile_num-1:0] req_m;
  logic                rd_valid_q, rd_last_q;

  assign grant_en = !reset &&
                    ((state_q == S_ARMED) ||
                     ((state_q == S_TRIG) && (post_cnt != '0)));
  assign req_m    = src_req & src_mask;

  // Round-robin search starting at the current priority source.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    src_ack = '0;
    if (grant_en) begin
      for (int i = 0; i < Tile_num; i++) begin
        cand = PW'((int'(prio_q) + i) % Tile_num);
        if (!found && req_m[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (found) src_ack[gnt_idx] = 1'b1;
  end

  assign prio_next  = (gnt_idx == PW'(Tile_num - 1)) ? '0 : gnt_idx + 1'b1;
  assign tb_wr_en   = found;
  assign tb_wr_addr = wr_ptr;
  assign tb_din     = src_data[int'(gnt_idx)*Fpay +: Fpay];

  assign arm_take = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign rd_take  = rd_start && !arm && (state_q == S_DONE);
  assign rd_issue = rd_next && !reset && (state_q == S_READ);
  assign rd_len   = wrapped_q ? {1'b1, {TB_AW{1'b0}}} : {1'b0, wr_ptr};

  assign tb_rd_en   = rd_issue;
  assign tb_rd_addr = rd_ptr;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  assign state      = state_q;
  assign wrapped    = wrapped_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arm) state_d = S_ARMED;
      S_ARMED: begin
        if (stop)         state_d = S_DONE;
        else if (trig_in) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (stop || (post_cnt == '0))              state_d = S_DONE;
        else if (found && (post_cnt == TB_AW'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        if (arm)          state_d = S_ARMED;
        else if (rd_start) state_d = (rd_len == '0) ? S_IDLE : S_READ;
      end
      S_READ:  if (rd_next && (rd_rem == (TB_AW+1)'(1))) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_rem     <= '0;
      post_cnt   <= '0;
      wrapped_q  <= 1'b0;
      prio_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm_take) begin
        wr_ptr    <= '0;
        wrapped_q <= 1'b0;
        prio_q    <= '0;
      end else if (found) begin
        wr_ptr <= wr_ptr + 1'b1;
        prio_q <= prio_next;
        if (&wr_ptr) wrapped_q <= 1'b1;
      end
      // A write in the trigger cycle is pre-trigger, so the load wins.
      if ((state_q == S_ARMED) && trig_in && !stop) post_cnt <= post_len;
      else if ((state_q == S_TRIG) && found)        post_cnt <= post_cnt - 1'b1;
      if (rd_take) begin
        rd_ptr <= wrapped_q ? wr_ptr : '0;
        rd_rem <= rd_len;
      end else if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_rem <= rd_rem - 1'b1;
      end
      rd_valid_q <= rd_issue;
      rd_last_q  <= rd_issue && (rd_rem == (TB_AW+1)'(1));
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: directed capture/readout scenarios plus random
// sessions, checked against a write-history reference model via scoreboards.
module tb_trace_capture_ctrl;
  localparam int FPAY  = 32;
  localparam int NT    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int WW    = NT + AW + FPAY;
  localparam int M_IDLE = 0, M_ARMED = 1, M_TRIG = 2, M_DONE = 3, M_READ = 4;

  logic clk = 1'b0;
  logic reset, arm, stop, trig_in, rd_next, rd_start;
  logic [AW-1:0]      post_len;
  logic [NT-1:0]      src_mask, src_req, src_ack;
  logic [NT*FPAY-1:0] src_data;
  logic               tb_wr_en, tb_rd_en, rd_valid, rd_last, wrapped;
  logic [AW-1:0]      tb_wr_addr, tb_rd_addr;
  logic [FPAY-1:0]    tb_din, rd_data;
  logic [2:0]         state;
  logic [FPAY-1:0]    mem [DEPTH];

  always #5 clk = ~clk;

  trace_capture_ctrl #(.Fpay(FPAY), .Tile_num(NT), .TB_AW(AW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop), .trig_in(trig_in),
    .post_len(post_len), .src_mask(src_mask), .src_req(src_req),
    .src_data(src_data), .src_ack(src_ack), .tb_wr_en(tb_wr_en),
    .tb_wr_addr(tb_wr_addr), .tb_din(tb_din), .tb_rd_en(tb_rd_en),
    .tb_rd_addr(tb_rd_addr), .rd_next(rd_next), .rd_start(rd_start),
    .rd_valid(rd_valid), .rd_last(rd_last), .state(state), .wrapped(wrapped)
  );

  // Trace buffer with one-cycle read latency.
  always @(posedge clk) begin
    if (tb_wr_en) mem[tb_wr_addr] <= tb_din;
    if (tb_rd_en) rd_data <= mem[tb_rd_addr];
  end

  int vectors = 0, miscompares = 0;
  logic [WW-1:0]      exp_w_q[$];
  logic [AW-1:0]      exp_r_q[$];
  logic [FPAY:0]      exp_v_q[$];
  logic [AW+FPAY-1:0] m_hist[$], m_rd[$];
  int m_state = M_IDLE, m_nwr = 0, m_prio = 0, m_post = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call consumes the inputs of the current cycle.
  task automatic model_step();
    int g;
    logic [FPAY-1:0] d;
    logic [AW-1:0] a;
    logic [AW+FPAY-1:0] e;
    if (reset) begin
      m_state = M_IDLE; m_nwr = 0; m_prio = 0; m_post = 0;
      m_hist.delete(); m_rd.delete();
      return;
    end
    g = -1;
    if (m_state == M_ARMED || (m_state == M_TRIG && m_post > 0))
      for (int k = 0; k < NT; k++)
        if (g < 0 && src_req[(m_prio + k) % NT] && src_mask[(m_prio + k) % NT])
          g = (m_prio + k) % NT;
    if (g >= 0) begin
      d = src_data[g*FPAY +: FPAY];
      a = AW'(m_nwr % DEPTH);
      exp_w_q.push_back({NT'(1 << g), a, d});
      m_hist.push_back({a, d});
      if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
      m_nwr++;
      m_prio = (g + 1) % NT;
    end
    case (m_state)
      M_IDLE: if (arm) begin m_state = M_ARMED; m_nwr = 0; m_prio = 0; m_hist.delete(); end
      M_ARMED: begin
        if (stop) m_state = M_DONE;
        else if (trig_in) begin m_state = M_TRIG; m_post = int'(post_len); end
      end
      M_TRIG: begin
        if (stop || m_post == 0) m_state = M_DONE;
        else if (g >= 0) begin
          m_post--;
          if (m_post == 0) m_state = M_DONE;
        end
      end
      M_DONE: begin
        if (arm) begin m_state = M_ARMED; m_nwr = 0; m_prio = 0; m_hist.delete(); end
        else if (rd_start) begin
          m_rd = m_hist;
          m_state = (m_rd.size() == 0) ? M_IDLE : M_READ;
        end
      end
      M_READ: if (rd_next) begin
        e = m_rd.pop_front();
        exp_r_q.push_back(e[AW+FPAY-1:FPAY]);
        exp_v_q.push_back({(m_rd.size() == 0), e[FPAY-1:0]});
        if (m_rd.size() == 0) m_state = M_IDLE;
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic step();
    model_step();
    @(posedge clk); #1;
    check("state", 64'(state), 64'(m_state));
    check("wrapped", 64'(wrapped), 64'(m_nwr >= DEPTH));
    arm = 0; stop = 0; trig_in = 0; rd_start = 0; rd_next = 0; reset = 0;
    src_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Monitor: pops an expectation whenever the DUT presents a transfer.
  initial begin
    logic [WW-1:0] ew;
    logic [FPAY:0] ev;
    forever begin
      @(negedge clk);
      if (tb_wr_en) begin
        if (exp_w_q.size() == 0) check("wr_unexpected", 64'(tb_wr_en), 64'(0));
        else begin
          ew = exp_w_q.pop_front();
          check("wr_ack",  64'(src_ack),    64'(ew[WW-1 -: NT]));
          check("wr_addr", 64'(tb_wr_addr), 64'(ew[FPAY +: AW]));
          check("wr_data", 64'(tb_din),     64'(ew[FPAY-1:0]));
        end
      end else check("ack_idle", 64'(src_ack), 64'(0));
      if (tb_rd_en) begin
        if (exp_r_q.size() == 0) check("rd_unexpected", 64'(tb_rd_en), 64'(0));
        else check("rd_addr", 64'(tb_rd_addr), 64'(exp_r_q.pop_front()));
      end
      if (rd_valid) begin
        if (exp_v_q.size() == 0) check("valid_unexpected", 64'(rd_valid), 64'(0));
        else begin
          ev = exp_v_q.pop_front();
          check("rd_last", 64'(rd_last), 64'(ev[FPAY]));
          check("rd_word", 64'(rd_data), 64'(ev[FPAY-1:0]));
        end
      end else check("last_idle", 64'(rd_last), 64'(0));
    end
  end

  task automatic readout_dir(input int start, input int n);
    rd_start = 1; step();
    for (int j = 0; j < n; j++) begin
      if ($urandom_range(0, 2) == 0) step();
      rd_next = 1; #1;
      check("dir_rd_addr", 64'(tb_rd_addr), 64'((start + j) % DEPTH));
      step();
    end
    check("dir_rd_end", 64'(state), 64'(M_IDLE));
    step(); step();
  endtask

  task automatic readout_rand();
    rd_start = 1; step();
    for (int i = 0; i < 100 && m_state == M_READ; i++) begin
      rd_next = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    step(); step();
  endtask

  task automatic fill(input int n);
    src_mask = '1;
    for (int i = 0; i < 200 && m_nwr < n; i++) begin
      src_req = NT'($urandom_range(1, 15)); step();
    end
    src_req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $finish;
  end

  initial begin
    reset = 1; arm = 0; stop = 0; trig_in = 0; rd_next = 0; rd_start = 0;
    post_len = '0; src_mask = '1; src_req = '1; src_data = '0;
    step(); reset = 1; src_req = '1; step();
    check("rst_wr_en", 64'(tb_wr_en), 64'(0));
    check("rst_ack", 64'(src_ack), 64'(0));
    check("rst_rd_en", 64'(tb_rd_en), 64'(0));
    check("rst_valid", 64'(rd_valid), 64'(0));
    check("rst_last", 64'(rd_last), 64'(0));
    check("rst_state", 64'(state), 64'(M_IDLE));

    // Round-robin with all sources requesting.
    arm = 1; step();
    src_mask = 4'b1111; src_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ack", 64'(src_ack), 64'(4'b0001 << (k % 4)));
      check("rr_addr", 64'(tb_wr_addr), 64'(k));
      step();
    end
    src_req = '0; stop = 1; step();
    readout_dir(0, 5);

    // Single source, trigger at write 5, three post-trigger words.
    arm = 1; step();
    src_mask = 4'b0100;
    for (int i = 0; i < 40 && m_state != M_DONE; i++) begin
      src_req = NT'($urandom) | 4'b0100;
      if (m_nwr == 5 && m_state == M_ARMED) begin trig_in = 1; post_len = 3; end
      step();
    end
    check("trig_done", 64'(state), 64'(M_DONE));
    check("trig_wrapped", 64'(wrapped), 64'(0));
    readout_dir(0, 9);

    // Wrap: DEPTH+3 pre-trigger writes, then stop.
    arm = 1; step();
    fill(DEPTH + 3);
    stop = 1; step();
    check("wrap_flag", 64'(wrapped), 64'(1));
    readout_dir(3, DEPTH);

    // Trigger with zero post length.
    arm = 1; step();
    src_mask = '1; src_req = '1; step(); step();
    trig_in = 1; post_len = 0; step();
    #1; check("pl0_no_wr", 64'(tb_wr_en), 64'(0));
    check("pl0_trig", 64'(state), 64'(M_TRIG));
    step();
    check("pl0_done", 64'(state), 64'(M_DONE));
    src_req = '0;
    readout_rand();

    // Reset during readout with four words remaining.
    arm = 1; step();
    fill(8);
    stop = 1; step();
    rd_start = 1; step();
    for (int j = 0; j < 4; j++) begin rd_next = 1; step(); end
    step();
    reset = 1; step();
    check("rr_rst_state", 64'(state), 64'(M_IDLE));
    check("rr_rst_valid", 64'(rd_valid), 64'(0));
    rd_next = 1; #1;
    check("rr_rst_rd_en", 64'(tb_rd_en), 64'(0));
    step();

    // Random capture sessions.
    for (int s = 0; s < 14; s++) begin
      arm = 1; step();
      for (int c = 0; c < 60 && (m_state == M_ARMED || m_state == M_TRIG); c++) begin
        src_mask = NT'($urandom); src_req = NT'($urandom);
        post_len = AW'($urandom_range(0, 12));
        trig_in  = ($urandom_range(0, 9) == 0);
        stop     = ($urandom_range(0, 39) == 0);
        arm      = ($urandom_range(0, 9) == 0);
        rd_next  = ($urandom_range(0, 3) == 0);
        rd_start = ($urandom_range(0, 9) == 0);
        step();
      end
      src_req = '0;
      if (m_state != M_DONE) begin stop = 1; step(); end
      if ($urandom_range(0, 3) != 0) readout_rand();
    end
    step(); step();

    check("drain_wr", 64'(exp_w_q.size()), 64'(0));
    check("drain_rd", 64'(exp_r_q.size()), 64'(0));
    check("drain_valid", 64'(exp_v_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
